retro_catc_gen: RTL



---
 rtl/retro_catc_gen_if.sv | 4 +
 rtl/retro_catc_gen.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/retro_catc_gen_if.sv
// System clock/reset bundle feeding the retro clock-enable generator.
interface retro_catc_gen_if (input logic CLK, input logic RST);
  modport sys (input CLK, input RST);
endinterface

// File: rtl/retro_catc_gen.sv
// Phase-accumulator tick generator for emulated retro cores, with a stall-tolerant
// backlog that replays buffered ticks at a throttled rate once the core can accept them.
module retro_catc_gen #(
  parameter int CoreClock   = 200000000,
  parameter int TargetClock = 8388608,
  parameter int AccWidth    = 32,
  parameter int MaxBacklog  = 15,
  parameter int CatchUpGap  = 1
) (
  retro_catc_gen_if.sys                   SysCon,
  input  logic                            Enable,
  input  logic                            Speed2x,
  input  logic                            Stall,
  input  logic                            ClearOverflow,
  output logic                            ClkEn,
  output logic                            ClkEnOut,
  output logic [$clog2(MaxBacklog+1)-1:0] Backlog,
  output logic                            Overflow,
  output logic                            CatchUp
);

  localparam int BW = $clog2(MaxBacklog + 1);
  localparam int GW = (CatchUpGap > 0) ? $clog2(CatchUpGap + 1) : 1;

  function automatic logic [63:0] round_div(input logic [63:0] num, input logic [63:0] den);
    return (num + (den >> 1)) / den;
  endfunction

  localparam logic [AccWidth-1:0] INCREMENT =
    AccWidth'(round_div(64'(TargetClock) << AccWidth, 64'(CoreClock)));
  localparam logic [AccWidth-1:0] INC_2X  = INCREMENT << 1;
  localparam logic [BW-1:0]       BL_MAX  = BW'(MaxBacklog);
  localparam logic [GW-1:0]       GAP_LEN = GW'(CatchUpGap);

  typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_CATCHUP} state_t;

  state_t              state_q, state_d;
  logic [AccWidth-1:0] acc_q, acc_d;
  logic                clk_en_q, clk_en_d;
  logic [BW-1:0]       backlog_q, backlog_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic                overflow_q, overflow_d;

  logic [AccWidth-1:0] inc_eff;
  logic [AccWidth:0]   sum;
  logic                clk_en_out;
  logic                buffer_tick;
  logic                release_tick;
  logic                loss;

  always_comb begin
    inc_eff  = Speed2x ? INC_2X : INCREMENT;
    sum      = {1'b0, acc_q} + {1'b0, inc_eff};
    acc_d    = acc_q;
    clk_en_d = 1'b0;
    if (Enable) begin
      acc_d    = sum[AccWidth-1:0];
      clk_en_d = sum[AccWidth];
    end
  end

  always_comb begin
    state_d      = state_q;
    backlog_d    = backlog_q;
    gap_d        = gap_q;
    clk_en_out   = 1'b0;
    buffer_tick  = 1'b0;
    release_tick = 1'b0;
    loss         = 1'b0;

    // A stall overrides every state: the tick in flight is parked, never delivered.
    if (Stall) begin
      buffer_tick = clk_en_q;
      gap_d       = '0;
      state_d     = ST_HOLD;
    end else begin
      case (state_q)
        ST_RUN: begin
          clk_en_out = clk_en_q;
          gap_d      = '0;
        end
        ST_HOLD: begin
          buffer_tick = clk_en_q;
        end
        ST_CATCHUP: begin
          if (gap_q != '0) begin
            buffer_tick = clk_en_q;
            gap_d       = gap_q - GW'(1);
          end else if (backlog_q != '0) begin
            release_tick = 1'b1;
            clk_en_out   = 1'b1;
            gap_d        = GAP_LEN;
          end else begin
            clk_en_out = clk_en_q;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end

    // A raw tick arriving with a release simply takes the released tick's place.
    if (release_tick) begin
      if (!clk_en_q) backlog_d = backlog_q - BW'(1);
    end else if (buffer_tick) begin
      if (backlog_q == BL_MAX) loss = 1'b1;
      else                     backlog_d = backlog_q + BW'(1);
    end

    if (!Stall && (state_q != ST_RUN)) begin
      state_d = (backlog_d != '0) ? ST_CATCHUP : ST_RUN;
    end

    overflow_d = loss | (overflow_q & ~ClearOverflow);
  end

  always_ff @(posedge SysCon.CLK or posedge SysCon.RST) begin
    if (SysCon.RST) begin
      state_q    <= ST_RUN;
      acc_q      <= '0;
      clk_en_q   <= 1'b0;
      backlog_q  <= '0;
      gap_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      clk_en_q   <= clk_en_d;
      backlog_q  <= backlog_d;
      gap_q      <= gap_d;
      overflow_q <= overflow_d;
    end
  end

  assign ClkEn    = clk_en_q;
  assign ClkEnOut = clk_en_out;
  assign Backlog  = backlog_q;
  assign Overflow = overflow_q;
  assign CatchUp  = (state_q == ST_CATCHUP);

endmodule
